// File: rtl/apb_arb_master.sv
// apb_arb_master -- two-requester round-robin APB master with PREADY timeout.
// Revision: 1.0
`default_nettype none

module apb_arb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_done,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                req_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_q;
  logic                winner_q;
  logic [1:0]          req_done_q;
  logic [DATA_W-1:0]   req_rdata_q;
  logic                req_err_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;

  logic [1:0]          elig;
  logic                grant_d;
  logic                pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;

  // A requester whose done pulse is on the bus this cycle is not re-eligible yet.
  assign elig = req_valid & ~req_done_q;

  always_comb begin
    grant_d = 1'b0;
    case (elig)
      2'b01:   grant_d = 1'b0;
      2'b10:   grant_d = 1'b1;
      2'b11:   grant_d = ~last_q;
      default: grant_d = 1'b0;
    endcase
  end

  assign pwrite_d = grant_d ? req_write[1] : req_write[0];
  assign paddr_d  = grant_d ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign pwdata_d = grant_d ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      winner_q    <= 1'b0;
      req_done_q  <= '0;
      req_rdata_q <= '0;
      req_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      req_done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|elig) begin
            state_q   <= ST_SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            winner_q  <= grant_d;
            last_q    <= grant_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            cnt_q     <= '0;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          // pready is checked first so a completion on the last allowed cycle is normal.
          if (pready) begin
            state_q              <= ST_IDLE;
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            req_done_q[winner_q] <= 1'b1;
            req_rdata_q          <= pwrite_q ? '0 : prdata;
            req_err_q            <= pslverr;
          end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            state_q              <= ST_IDLE;
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            req_done_q[winner_q] <= 1'b1;
            req_rdata_q          <= '0;
            req_err_q            <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_done  = req_done_q;
  assign req_rdata = req_rdata_q;
  assign req_err   = req_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

`default_nettype wire
